// File: rtl/filter_pkg.sv
// Purpose: shared pixel/window constants, FSM encoding and window slot addressing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package filter_pkg;

  localparam int PIX_W = 10;
  localparam int K     = 9;
  localparam int BUS_W = K * K * PIX_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // LSB of window slot (r,c); r=0 is the oldest line, c=0 the oldest column.
  function automatic int slot_lsb(input int r, input int c);
    return PIX_W * (K * r + c);
  endfunction

endpackage

// File: rtl/window_builder_line_delay.sv
// Purpose: one raster line of delay, a circular register array advanced only on i_en.
// Latency: o_dat is the pixel written exactly IMG_W enables ago (read-before-write).
// Backpressure: none; holds completely while i_en is low.
module line_delay #(
  parameter int PIX_W = filter_pkg::PIX_W,
  parameter int IMG_W = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [PIX_W-1:0] i_dat,
  output logic [PIX_W-1:0] o_dat
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [AW-1:0] ADDR_LAST = AW'(IMG_W - 1);

  logic [PIX_W-1:0] r_mem [IMG_W];
  logic [AW-1:0]    r_addr;

  // Single wrapping address shared by the read and the write.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_addr <= '0;
    end else if (i_en) begin
      r_addr <= (r_addr == ADDR_LAST) ? '0 : r_addr + AW'(1);
    end
  end

  // Storage is intentionally not cleared: a full prefill always precedes use.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_mem[r_addr] <= i_dat;
    end
  end

  assign o_dat = r_mem[r_addr];

endmodule

// File: rtl/window_builder.sv
// Purpose: raster pixel stream -> 9x9 neighbourhood window plus refresh strobe for the filter core.
// Latency: 1 cycle from pixel acceptance to data_bus/refresh update.
// Backpressure: none; every pix_valid is accepted, pix_valid=0 freezes all state.
module window_builder
  import filter_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sof,
  input  logic             i_pix_valid,
  input  logic [PIX_W-1:0] i_pix_in,
  output logic [BUS_W-1:0] o_data_bus,
  output logic             o_refresh,
  output logic             o_frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_FULL = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(K - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             w_start;
  logic             w_accept;
  logic             w_last;
  logic             w_refresh_set;
  logic [PIX_W-1:0] w_tap [K];
  logic [BUS_W-1:0] r_bus;
  logic             r_refresh;

  assign w_start  = i_sof & i_pix_valid;
  assign w_accept = w_start | (i_pix_valid & (r_state == ST_RUN));
  assign w_last   = (r_col == COL_LAST) && (r_row == ROW_LAST);

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: sof with a valid pixel restarts from any state.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_start) begin
          w_state_nxt = ST_RUN;
        end else if (i_pix_valid && w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: if (w_start) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: the sof pixel is (0,0) and can never complete a window.
  always_comb begin
    o_frame_done  = (r_state == ST_DONE);
    w_refresh_set = i_pix_valid && !i_sof && (r_state == ST_RUN) &&
                    (r_row >= ROW_FULL) && (r_col >= COL_FULL);
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_start) begin
      r_col <= COL_W'(1);
      r_row <= '0;
    end else if (w_accept) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Tap 0 is the live pixel; tap j is the same column j lines earlier.
  assign w_tap[0] = i_pix_in;

  for (genvar j = 1; j < K; j++) begin : g_line
    line_delay #(
      .PIX_W(PIX_W),
      .IMG_W(IMG_W)
    ) u_line_delay (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_en (w_accept),
      .i_dat(w_tap[j-1]),
      .o_dat(w_tap[j])
    );
  end

  // Window: every row shifts one column left, new column enters at c=K-1.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_bus <= '0;
    end else if (w_accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          r_bus[slot_lsb(r, c) +: PIX_W] <= r_bus[slot_lsb(r, c + 1) +: PIX_W];
        end
        r_bus[slot_lsb(r, K - 1) +: PIX_W] <= w_tap[K-1-r];
      end
    end
  end

  // Refresh marks the edge on which a fully in-frame window lands.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_refresh <= 1'b0;
    end else begin
      r_refresh <= w_refresh_set;
    end
  end

  assign o_data_bus = r_bus;
  assign o_refresh  = r_refresh;

endmodule

// File: tb/tb_window_builder.sv
// Purpose: randomized scoreboard bench for window_builder with a frame-image reference model.
// Latency: expects window/refresh one cycle after the accepting edge.
// Backpressure: none; stimulus varies pix_valid density only.
module tb_window_builder;
  import filter_pkg::*;

  localparam int TW     = 16;
  localparam int TH     = 12;
  localparam int NPIX   = TW * TH;
  localparam int N_REF  = (TW - K + 1) * (TH - K + 1);
  localparam int FIRST  = (K - 1) * TW + (K - 1);

  logic             clk = 1'b0;
  logic             i_rst;
  logic             i_sof;
  logic             i_pix_valid;
  logic [PIX_W-1:0] i_pix_in;
  logic [BUS_W-1:0] o_data_bus;
  logic             o_refresh;
  logic             o_frame_done;

  always #5 clk = ~clk;

  window_builder #(.IMG_W(TW), .IMG_H(TH)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_sof       (i_sof),
    .i_pix_valid (i_pix_valid),
    .i_pix_in    (i_pix_in),
    .o_data_bus  (o_data_bus),
    .o_refresh   (o_refresh),
    .o_frame_done(o_frame_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: frame image plus raster position, from the frame rules.
  logic [BUS_W-1:0] exp_q [$];
  logic [PIX_W-1:0] img [TH][TW];
  int  m_state = 0;   // 0 idle, 1 running, 2 frame complete
  int  m_row = 0;
  int  m_col = 0;
  bit  m_last_pv = 1'b0;
  bit  exp_clear = 1'b0;

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_step(input bit rst_v, input bit pv, input bit sf,
                                     input logic [PIX_W-1:0] pix);
    logic [BUS_W-1:0] w;
    m_last_pv = pv;
    if (!rst_v) begin
      m_state   = 0;
      m_row     = 0;
      m_col     = 0;
      exp_clear = 1'b1;
      return;
    end
    if (!pv) return;
    if (sf) begin
      m_state = 1;
      m_row   = 0;
      m_col   = 0;
    end else if (m_state != 1) begin
      return;
    end
    img[m_row][m_col] = pix;
    if (m_row >= K - 1 && m_col >= K - 1) begin
      w = '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          w[PIX_W*(K*r+c) +: PIX_W] = img[m_row-(K-1)+r][m_col-(K-1)+c];
      exp_q.push_back(w);
    end
    m_col++;
    if (m_col == TW) begin
      m_col = 0;
      m_row++;
      if (m_row == TH) begin
        m_row   = 0;
        m_state = 2;
      end
    end
  endfunction

  task automatic cycle(input bit rst_v, input bit pv, input bit sf, input logic [PIX_W-1:0] pix);
    i_rst       = rst_v;
    i_pix_valid = pv;
    i_sof       = sf;
    i_pix_in    = pix;
    @(posedge clk);
    model_step(rst_v, pv, sf, pix);
    #1;
  endtask

  // Monitor: pops an expected window whenever the DUT flags refresh.
  always @(negedge clk) begin
    if (exp_clear) begin
      chk_bus("reset_data_bus", o_data_bus, '0);
      chk_int("reset_refresh", int'(o_refresh), 0);
      chk_int("reset_frame_done", int'(o_frame_done), 0);
      exp_clear = 1'b0;
    end
    if (!m_last_pv) chk_int("refresh_after_invalid", int'(o_refresh), 0);
    chk_int("frame_done_level", int'(o_frame_done), int'(m_state == 2));
    if (o_refresh === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_refresh: got refresh=1 with no window pending");
      end else begin
        chk_bus("window", o_data_bus, exp_q.pop_front());
      end
    end
  end

  // pvmode: 0 continuous, 1 valid pattern 1,0,0, 2 random ~60% valid.
  task automatic run_frame(input int pvmode, input int restart_at, input int rst_at,
                           input bit pattern, output int n_ref, output int first_idx);
    int k, cyc;
    bit pv, sf, restarted, was_reset;
    logic [PIX_W-1:0] pix;
    k = 0; cyc = 0; n_ref = 0; first_idx = -1; restarted = 0; was_reset = 0;
    while (k < NPIX) begin
      if (k == 0)           pv = 1'b1;
      else if (pvmode == 0) pv = 1'b1;
      else if (pvmode == 1) pv = (cyc % 3 == 0);
      else                  pv = ($urandom_range(99) < 60);
      sf = pv && (k == 0);
      if (pv && !restarted && restart_at >= 0 && k == restart_at) begin
        sf = 1'b1; restarted = 1'b1; k = 0; n_ref = 0; first_idx = -1;
      end
      pix = pattern ? PIX_W'(k) : PIX_W'($urandom);
      cycle(1'b1, pv, sf, pix);
      if (sf) chk_int("frame_done_clears_on_sof", int'(o_frame_done), 0);
      if (o_refresh) begin
        n_ref++;
        if (first_idx < 0) begin
          first_idx = k;
          if (pattern) begin
            chk_int("slot_0_0", int'(o_data_bus[slot_lsb(0,0) +: PIX_W]), 0);
            chk_int("slot_0_8", int'(o_data_bus[slot_lsb(0,8) +: PIX_W]), 8);
            chk_int("slot_8_0", int'(o_data_bus[slot_lsb(8,0) +: PIX_W]), 128);
            chk_int("slot_8_8", int'(o_data_bus[slot_lsb(8,8) +: PIX_W]), 136);
          end
        end
      end
      if (pv) k++;
      cyc++;
      if (rst_at >= 0 && !was_reset && k == rst_at + 1) begin
        cycle(1'b0, 1'b1, 1'b0, PIX_W'($urandom));
        chk_int("mid_reset_refresh", int'(o_refresh), 0);
        chk_bus("mid_reset_data_bus", o_data_bus, '0);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, PIX_W'($urandom));
        was_reset = 1'b1; k = 0; n_ref = 0; first_idx = -1;
      end
    end
    chk_int("frame_done_after_last", int'(o_frame_done), 1);
  endtask

  initial begin
    int n_ref, first_idx, extra;
    i_rst = 1'b0; i_sof = 1'b0; i_pix_valid = 1'b0; i_pix_in = '0;
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    // Pixels without sof are ignored while idle.
    repeat (5) cycle(1'b1, 1'b1, 1'b0, PIX_W'($urandom));

    run_frame(0, -1, -1, 1'b1, n_ref, first_idx);
    chk_int("cont_refresh_count", n_ref, N_REF);
    chk_int("cont_first_refresh", first_idx, FIRST);

    extra = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'b0, PIX_W'($urandom));
      if (o_refresh) extra++;
    end
    chk_int("done_ignores_pixels", extra, 0);
    chk_int("done_holds_frame_done", int'(o_frame_done), 1);

    run_frame(1, -1, -1, 1'b1, n_ref, first_idx);
    chk_int("toggle_refresh_count", n_ref, N_REF);
    chk_int("toggle_first_refresh", first_idx, FIRST);

    run_frame(2, -1, 150, 1'b0, n_ref, first_idx);
    chk_int("reset_refresh_count", n_ref, N_REF);
    chk_int("reset_first_refresh", first_idx, FIRST);

    run_frame(0, 100, -1, 1'b1, n_ref, first_idx);
    chk_int("restart_refresh_count", n_ref, N_REF);
    chk_int("restart_first_refresh", first_idx, FIRST);

    for (int f = 0; f < 3; f++) begin
      run_frame(2, -1, -1, 1'b0, n_ref, first_idx);
      chk_int("b2b_refresh_count", n_ref, N_REF);
    end

    repeat (3) cycle(1'b1, 1'b0, 1'b0, '0);
    chk_int("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
